ex_mem_stage_pipe: RTL and testbench
====================================

// Module: ex_mem_stage_pipe
// PURPOSE
//  Parametrised EX->MEM pipeline stage with valid/ready handshake and 2-entry skid buffer.
//  Replaces the fixed free-running EX/MEM latch: downstream back-pressure stalls EX without
//  losing data; flush kills all in-flight entries. Sits between ALU/branch-compare and data memory.
// PARAMETERS
//  DATA_W   64  width of PCplusimm, ALU_result, WriteData fields
//  FUNCT_W  4   width of funct field
//  RD_W     5   destination register index width
//  CTRL_W   7   control bits {RegWrite,MemtoReg,Branch,Zero,MemWrite,MemRead,Is_Greater}
//  PAYLOAD_W = CTRL_W+3*DATA_W+FUNCT_W+RD_W (derived, 208 at defaults; not overridable)
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  flush        in   1          synchronous kill of all held and incoming entries
//  in_valid     in   1          EX presents a payload
//  in_ready     out  1          stage can accept; registered (= skid slot empty)
//  in_payload   in   PAYLOAD_W  packed ex_mem_payload_t from EX
//  out_valid    out  1          MEM-side payload valid
//  out_ready    in   1          MEM consumes this cycle
//  out_payload  out  PAYLOAD_W  packed payload to MEM
//  occupancy    out  2          entries held: 0,1,2
//  stall_cnt    out  32         back-pressure cycle count (STAGE_PERF_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, skid valid=0, out_payload=0, skid payload=0,
//    in_ready=1, occupancy=0, stall_cnt=0. Deassertion sync'd externally; no transfer on reset cycle.
//  - accept = in_valid & in_ready; fire = out_valid & out_ready. Latency 1 cycle, 1 entry/cycle.
//  - Slots: MAIN (drives out_*) and SKID. in_ready = !skid_valid (flop, never comb from out_ready).
//  - Per edge, flush=0:
//     MAIN empty or fire, SKID empty : accept -> MAIN<=in; else MAIN valid<=0.
//     MAIN empty or fire, SKID full  : MAIN<=SKID, SKID valid<=0 (in_ready was 0, no accept).
//     MAIN full, !fire, accept       : SKID<=in (occupancy 1->2, in_ready falls next cycle).
//     MAIN full, !fire, no accept    : hold.
//  - Ordering strictly FIFO; entry never duplicated or dropped without flush.
//  - Payload held stable while out_valid & !out_ready.
//  - Invalid slot payload reads 0 (bubbles are all-zero so MemWrite/RegWrite are 0).
//  - flush=1 (priority over everything): both valids<=0, both payloads<=0, incoming accept
//    discarded, fire this cycle still counts as consumed by MEM. in_ready=1 next cycle.
//  - flush with rst_n low: reset wins. Flush on an empty stage: no effect.
//  - occupancy = out_valid + skid_valid, registered.
// CONFIGURATION
//  STAGE_PERF_EN defined: stall_cnt increments (saturating at 2^32-1) each cycle
//    out_valid & !out_ready; cleared by reset only, unaffected by flush.
//  undefined: stall_cnt port absent, no counter logic.
// STRUCTURE
//  Package ex_mem_pkg: ex_mem_ctrl_t struct (7 control bits, fixed order above),
//    ex_mem_payload_t {ctrl, pc_plus_imm, alu_result, write_data, funct, rd}, width localparams.
//  Sub-module pipe_slot: one valid+payload register with load, clear, hold; instantiated for
//    MAIN and SKID. Top holds steering mux and optional counter.
// TESTING
//  1 Reset mid-stream: 2 entries held, pull rst_n low async -> out_valid=0, occupancy=0,
//    in_ready=1 immediately, without a clock edge.
//  2 Streaming: out_ready=1, 8 back-to-back payloads rd=1..8 -> out in order, 1-cycle latency,
//    in_ready stays 1.
//  3 Back-pressure: out_ready=0 after entry A, send B,C -> B to SKID, occupancy=2, in_ready=0,
//    C held at EX; out_ready=1 -> A,B,C delivered in order, none lost.
//  4 Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_payload=0,
//    occupancy=0, in_ready=1; flushed entries never appear.
//  5 Flush and fire same cycle: MAIN fires with ALU_result=0xDEAD -> MEM sees it once,
//    SKID entry killed.
//  6 STAGE_PERF_EN: hold out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=10;
//    flush -> stall_cnt unchanged.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and widths for the EX->MEM pipeline stage.
// The payload struct matches the default widths; the stage itself is width-parametrised.
package ex_mem_pkg;

    localparam int EM_DATA_W  = 64;
    localparam int EM_FUNCT_W = 4;
    localparam int EM_RD_W    = 5;
    localparam int EM_CTRL_W  = 7;

    function automatic int payload_width(input int cw, input int dw, input int fw, input int rw);
        return cw + 3 * dw + fw + rw;
    endfunction

    localparam int EM_PAYLOAD_W = payload_width(EM_CTRL_W, EM_DATA_W, EM_FUNCT_W, EM_RD_W);

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic zero;
        logic mem_write;
        logic mem_read;
        logic is_greater;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t              ctrl;
        logic [EM_DATA_W-1:0]      pc_plus_imm;
        logic [EM_DATA_W-1:0]      alu_result;
        logic [EM_DATA_W-1:0]      write_data;
        logic [EM_FUNCT_W-1:0]     funct;
        logic [EM_RD_W-1:0]        rd;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_pipe_slot.sv
// One valid+payload register. Clear beats load; a cleared slot reads all-zero so
// an empty slot always looks like a harmless bubble.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_data;

endmodule

// File: rtl/ex_mem_stage_pipe.sv
// EX->MEM stage with valid/ready handshake and a two-entry (MAIN + SKID) buffer.
// Define STAGE_PERF_EN to add the saturating back-pressure counter on stall_cnt.
module ex_mem_stage_pipe
    import ex_mem_pkg::*;
#(
    parameter  int DATA_W    = EM_DATA_W,
    parameter  int FUNCT_W   = EM_FUNCT_W,
    parameter  int RD_W      = EM_RD_W,
    parameter  int CTRL_W    = EM_CTRL_W,
    localparam int PAYLOAD_W = payload_width(CTRL_W, DATA_W, FUNCT_W, RD_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
`ifdef STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    logic                 w_main_valid;
    logic                 w_skid_valid;
    logic [PAYLOAD_W-1:0] w_main_q;
    logic [PAYLOAD_W-1:0] w_skid_q;
    logic [PAYLOAD_W-1:0] w_main_d;
    logic                 w_main_load;
    logic                 w_main_clear;
    logic                 w_skid_load;
    logic                 w_skid_clear;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_main_free;

    assign w_accept    = in_valid & in_ready;
    assign w_fire      = w_main_valid & out_ready;
    assign w_main_free = ~w_main_valid | w_fire;

    // SKID always drains into MAIN first; while SKID is full in_ready is low, so no accept races it.
    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = in_payload;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_free) begin
            if (w_skid_valid) begin
                w_main_load  = 1'b1;
                w_main_d     = w_skid_q;
                w_skid_clear = 1'b1;
            end else if (w_accept) begin
                w_main_load  = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else if (w_accept) begin
            w_skid_load = 1'b1;
        end
    end

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_valid (w_main_valid),
        .o_q     (w_main_q)
    );

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (in_payload),
        .o_valid (w_skid_valid),
        .o_q     (w_skid_q)
    );

    assign in_ready    = ~w_skid_valid;
    assign out_valid   = w_main_valid;
    assign out_payload = w_main_q;
    assign occupancy   = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifdef STAGE_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_stage_pipe.sv
// Scoreboard bench for ex_mem_stage_pipe: accepted payloads are queued, a monitor pops
// and compares on every MEM-side transfer; directed checks cover reset, flush and stalls.
module tb_ex_mem_stage_pipe;
    import ex_mem_pkg::*;

    localparam int PW = EM_PAYLOAD_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_payload;
    logic [1:0]    occupancy;
`ifdef STAGE_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    int            checks = 0;
    int            errors = 0;
    int            dead_seen = 0;
    logic [PW-1:0] exp_q[$];

    ex_mem_stage_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .occupancy   (occupancy)
`ifdef STAGE_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ex_mem_payload_t mk(input logic [4:0] rd, input logic [63:0] alu);
        ex_mem_payload_t p;
        p = '0;
        p.ctrl.reg_write = 1'b1;
        p.ctrl.mem_write = rd[0];
        p.pc_plus_imm    = 64'h1000 + {59'd0, rd};
        p.alu_result     = alu;
        p.write_data     = ~alu;
        p.funct          = rd[3:0];
        p.rd             = rd;
        return p;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every MEM-side transfer must match the oldest accepted payload.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            ex_mem_payload_t o;
            o = out_payload;
            $display("OUT rd=%0d alu=%0h", o.rd, o.alu_result);
            if (o.alu_result == 64'hDEAD) dead_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected got=%0h exp=none", out_payload);
            end else begin
                chk("out_order", out_payload, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !flush && in_valid && in_ready) exp_q.push_back(in_payload);
    end

    always @(posedge clk) begin
        if (rst_n && flush) exp_q.delete();
    end

    task automatic send(input logic [PW-1:0] p);
        bit acc;
        ex_mem_payload_t s;
        acc = 1'b0;
        s = p;
        in_valid   = 1'b1;
        in_payload = p;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=not_accepted exp=accepted rd=%0d", s.rd);
        end else begin
            $display("IN  rd=%0d alu=%0h", s.rd, s.alu_result);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", PW'(exp_q.size()), '0);
        chk("drain_occupancy", PW'(occupancy), PW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", PW'(out_valid), PW'(0));
        chk("rst_in_ready", PW'(in_ready), PW'(1));
        chk("rst_occupancy", PW'(occupancy), PW'(0));
        chk("rst_out_payload", out_payload, '0);
`ifdef STAGE_PERF_EN
        chk("rst_stall_cnt", PW'(stall_cnt), PW'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: 1-cycle latency, in_ready never drops
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send(mk(5'(k), 64'h100 + 64'(k)));
            chk("stream_out_valid", PW'(out_valid), PW'(1));
            chk("stream_latency", out_payload, mk(5'(k), 64'h100 + 64'(k)));
            chk("stream_in_ready", PW'(in_ready), PW'(1));
        end
        idle(1);
        chk("bubble_out_valid", PW'(out_valid), PW'(0));
        chk("bubble_payload_zero", out_payload, '0);

        // Back-pressure: A in MAIN, B in SKID, C stalled at EX
        out_ready = 1'b0;
        send(mk(5'd9, 64'hA));
        send(mk(5'd10, 64'hB));
        chk("bp_occupancy2", PW'(occupancy), PW'(2));
        chk("bp_in_ready_low", PW'(in_ready), PW'(0));
        chk("bp_hold_payload", out_payload, mk(5'd9, 64'hA));
        in_valid   = 1'b1;
        in_payload = mk(5'd11, 64'hC);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_full", PW'(occupancy), PW'(2));
        chk("bp_still_a", out_payload, mk(5'd9, 64'hA));
        out_ready = 1'b1;
        send(mk(5'd11, 64'hC));
        drain();

        // Flush with both slots full and an incoming entry
        out_ready = 1'b0;
        send(mk(5'd12, 64'hD));
        send(mk(5'd13, 64'hE));
        in_valid   = 1'b1;
        in_payload = mk(5'd14, 64'hF);
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", PW'(out_valid), PW'(0));
        chk("flush_payload_zero", out_payload, '0);
        chk("flush_occupancy", PW'(occupancy), PW'(0));
        chk("flush_in_ready", PW'(in_ready), PW'(1));
        out_ready = 1'b1;
        idle(3);
        chk("flush_nothing_after", PW'(out_valid), PW'(0));

        // Flush coinciding with a MAIN fire
        out_ready = 1'b0;
        send(mk(5'd15, 64'hDEAD));
        send(mk(5'd16, 64'hBEEF));
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle(3);
        chk("flush_fire_seen_once", PW'(dead_seen), PW'(1));
        chk("flush_fire_empty", PW'(occupancy), PW'(0));

        // Asynchronous reset mid-stream, no clock edge needed
        out_ready = 1'b0;
        send(mk(5'd17, 64'h11));
        send(mk(5'd18, 64'h12));
        chk("pre_reset_occupancy", PW'(occupancy), PW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", PW'(out_valid), PW'(0));
        chk("async_rst_occupancy", PW'(occupancy), PW'(0));
        chk("async_rst_in_ready", PW'(in_ready), PW'(1));
        chk("async_rst_payload", out_payload, '0);
`ifdef STAGE_PERF_EN
        chk("async_rst_stall_cnt", PW'(stall_cnt), PW'(0));
`endif
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef STAGE_PERF_EN
        // Ten stalled cycles, then a flush that must not disturb the count
        out_ready = 1'b0;
        send(mk(5'd19, 64'h13));
        chk("perf_start", PW'(stall_cnt), PW'(0));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("perf_stall_10", PW'(stall_cnt), PW'(10));
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle(2);
        chk("perf_after_flush", PW'(stall_cnt), PW'(10));
        chk("perf_empty", PW'(out_valid), PW'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
